regread_arbiter: RTL and testbench

Round-robin arbiter sharing one register-file read port between up to NREQ requesters, e.g. decode read A/B and a debug/trace reader. It drives the 5-bit select of the 32:1 read-mux array and returns captured read data tagged with a one-hot valid. The block is pipelined: one grant per cycle, with fixed latency from request sample to data.

---
 rtl/regread_pkg.sv | 14 +
 rtl/regread_arbiter_rr_pick.sv | 26 ++
 rtl/regread_arbiter.sv | 84 ++++++++
 tb/tb_regread_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regread_pkg.sv
// Shared types and helpers for the register-file read-port arbiter.
// AW/DW here are the defaults; the arbiter takes its own parameters.
package regread_pkg;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 64;

   typedef logic [AW_DEF-1:0] reg_addr_t;
   typedef logic [DW_DEF-1:0] reg_data_t;

   // One-hot decode of a requester index; covers NREQ up to 8.
   function automatic logic [7:0] onehot(input logic [2:0] idx);
      onehot = 8'b1 << idx;
   endfunction
endpackage

// File: rtl/regread_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   pick,
   output logic            any
);
   always_comb begin
      int idx;
      pick = '0;
      any  = 1'b0;
      idx  = 0;
      // Scan from the far end so the nearest eligible index after ptr wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (eligible[idx]) begin
            pick = PW'(idx);
            any  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one register-file read port; two-stage pipeline
// (arbitrate -> capture), request-to-data latency of two cycles.
//
// state          | meaning
// IDLE           | gnt == 0, nothing being captured
// GRANT          | gnt != 0, port_sel drives the read mux
// GRANT+CAPTURE  | gnt != 0 and rd_valid != 0 on back-to-back grants
module regread_arbiter
   import regread_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] addr,
   input  logic             hold,
   output logic [NREQ-1:0]  gnt,
   output logic [AW-1:0]    port_sel,
   input  logic [DW-1:0]    port_data,
   output logic [NREQ-1:0]  rd_valid,
   output logic [DW-1:0]    rd_data
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [AW-1:0]   port_sel_q, port_sel_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] rd_valid_q, rd_valid_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;

   logic [NREQ-1:0] eligible;
   logic [PW-1:0]   pick;
   logic            any;

   // The current grantee is masked so a still-held req cannot double-grant.
   assign eligible = req & ~gnt_q;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .pick     (pick),
      .any      (any)
   );

   always_comb begin
      gnt_d      = '0;
      port_sel_d = port_sel_q;
      ptr_d      = ptr_q;
      if (!hold && any) begin
         gnt_d      = NREQ'(onehot(3'(pick)));
         port_sel_d = addr[pick*AW +: AW];
         ptr_d      = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
      end
   end

   always_comb begin
      rd_valid_d = gnt_q;
      rd_data_d  = (|gnt_q) ? port_data : rd_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q      <= '0;
         port_sel_q <= '0;
         ptr_q      <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         gnt_q      <= gnt_d;
         port_sel_q <= port_sel_d;
         ptr_q      <= ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign gnt      = gnt_q;
   assign port_sel = port_sel_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-level reference model.
module tb_regread_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 64;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] addr;
   logic               hold;
   logic [NREQ-1:0]    gnt;
   logic [AW-1:0]      port_sel;
   logic [DW-1:0]      port_data;
   logic [NREQ-1:0]    rd_valid;
   logic [DW-1:0]      rd_data;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int              m_ptr;
   logic [NREQ-1:0] m_gnt;
   logic [AW-1:0]   m_sel;
   logic [NREQ-1:0] m_rdv;
   logic [DW-1:0]   m_rdd;

   regread_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .addr      (addr),
      .hold      (hold),
      .gnt       (gnt),
      .port_sel  (port_sel),
      .port_data (port_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data)
   );

   // Read-mux array stand-in: data = 0x700 + select.
   assign port_data = 64'h700 + DW'(port_sel);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      m_ptr = 0;
      m_gnt = '0;
      m_sel = '0;
      m_rdv = '0;
      m_rdd = '0;
   endtask

   // One rising edge of the reference: capture uses last cycle's grant and
   // select, then the next grantee is found by scanning from ptr.
   task automatic model_edge();
      logic [NREQ-1:0] elig;
      int pick;
      int idx;
      if (!reset_n) begin
         model_zero();
         return;
      end
      m_rdv = m_gnt;
      if (m_gnt != 0) m_rdd = 64'h700 + DW'(m_sel);
      elig = req & ~m_gnt;
      pick = -1;
      if (!hold) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (pick < 0 && elig[idx]) pick = idx;
         end
      end
      if (pick >= 0) begin
         m_gnt = NREQ'(1) << pick;
         m_sel = addr[pick*AW +: AW];
         m_ptr = (pick + 1) % NREQ;
      end else begin
         m_gnt = '0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("gnt", 64'(gnt), 64'(m_gnt));
      chk("port_sel", 64'(port_sel), 64'(m_sel));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("rd_data", rd_data, m_rdd);
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      addr[i*AW +: AW] = a;
   endtask

   logic [63:0] rr_exp [4];
   int          gcount [NREQ];

   initial begin
      rr_exp[0] = 64'h703;
      rr_exp[1] = 64'h709;
      rr_exp[2] = 64'h711;
      rr_exp[3] = 64'h71F;

      reset_n = 1'b0;
      req     = '0;
      addr    = '0;
      hold    = 1'b0;
      model_zero();
      @(negedge clk);
      @(negedge clk);
      chk("init_gnt", 64'(gnt), 64'd0);
      chk("init_rd_valid", 64'(rd_valid), 64'd0);
      reset_n = 1'b1;

      // Single read from requester 2
      req = 4'b0100;
      set_addr(2, 5'd7);
      step();
      chk("single_gnt", 64'(gnt), 64'h4);
      chk("single_sel", 64'(port_sel), 64'd7);
      req = '0;
      step();
      chk("single_rdv", 64'(rd_valid), 64'h4);
      chk("single_rdd", rd_data, 64'h707);

      // Reset mid-stream with all requesting and a grant in flight
      req = 4'b1111;
      set_addr(0, 5'd3);
      set_addr(1, 5'd9);
      set_addr(2, 5'd17);
      set_addr(3, 5'd31);
      step();
      reset_n = 1'b0;
      #1;
      model_zero();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_port_sel", 64'(port_sel), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      step();
      chk("rst_hold_rdv", 64'(rd_valid), 64'd0);
      reset_n = 1'b1;

      // Round robin 0,1,2,3 after release; each drops req after its grant
      for (int k = 0; k < 5; k++) begin
         step();
         if (k < 4) chk("rr_gnt", 64'(gnt), 64'(NREQ'(1) << k));
         if (k > 0) chk("rr_data", rd_data, rr_exp[k-1]);
         req = req & ~gnt;
      end

      // Wrap: grant 2 leaves ptr at 3, so 3 wins over 0
      req = 4'b0100;
      step();
      chk("wrap_g2", 64'(gnt), 64'h4);
      req = 4'b1001;
      step();
      chk("wrap_g3", 64'(gnt), 64'h8);
      req = req & ~gnt;
      step();
      chk("wrap_g0", 64'(gnt), 64'h1);
      req = '0;
      step();

      // Hold blocks new grants
      req  = 4'b0010;
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_gnt0", 64'(gnt), 64'd0);
      end
      hold = 1'b0;
      step();
      chk("hold_release", 64'(gnt), 64'h2);
      req = '0;
      step();

      // Grant issued before hold rises still completes
      req = 4'b0001;
      step();
      chk("hold_pre_gnt", 64'(gnt), 64'h1);
      req  = '0;
      hold = 1'b1;
      step();
      chk("hold_inflight_rdv", 64'(rd_valid), 64'h1);
      chk("hold_inflight_gnt", 64'(gnt), 64'd0);
      hold = 1'b0;

      // Single held requester: every other cycle
      req = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("held_pattern", 64'(gnt[0]), 64'((k % 2) == 0));
      end
      req = '0;
      step();
      step();

      // Fairness: all held continuously, 8 grants -> 2 each
      for (int i = 0; i < NREQ; i++) gcount[i] = 0;
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         for (int i = 0; i < NREQ; i++) if (gnt[i]) gcount[i]++;
      end
      for (int i = 0; i < NREQ; i++) chk("fair_count", 64'(gcount[i]), 64'd2);
      req = '0;
      step();

      // Randomized traffic obeying the requester protocol
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || gnt[i]) begin
               req[i] = ($urandom_range(0, 2) != 0);
               set_addr(i, AW'($urandom_range(0, 31)));
            end
         end
         hold = ($urandom_range(0, 7) == 0);
         if (c == 200) reset_n = 1'b0;
         if (c == 202) reset_n = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
